drp_master: RTL and testbench

- DRP initiator that drives the dynamic reconfiguration port (DEN/DWE/DADDR/DI in, DRDY/DO out) of a hard block such as the PCIE_2_1 instance.
- Accepts single read, write, or masked read-modify-write (RMW) requests over a valid/ready interface.
- Issues them one at a time on the DRP and returns read data or a timeout indication.
- Sits between board-level test logic (switch/UART control) and the hard block's DRP pins.

---
 rtl/drp_master.sv | 171 +++++++++++++++++
 tb/tb_drp_master.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drp_master.sv
`default_nettype none
// ============================================================================
// Module   : drp_master
// Purpose  : DRP initiator issuing single read, write or masked RMW accesses
//            to a hard block's dynamic reconfiguration port, with timeout.
// Revision : 1.0 - initial release
// ============================================================================
module drp_master #(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_mask,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  drp_en,
    output logic                  drp_we,
    output logic [ADDR_WIDTH-1:0] drp_addr,
    output logic [DATA_WIDTH-1:0] drp_di,
    input  logic                  drp_rdy,
    input  logic [DATA_WIDTH-1:0] drp_do
);

    localparam logic [DATA_WIDTH-1:0] c_all_ones = '1;
    // Counter starts at zero in the first wait cycle, so the last allowed
    // wait cycle is the one where it holds TIMEOUT_CYCLES-1.
    localparam logic [15:0]           c_cnt_last = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_WR_ISSUE = 3'd3,
        S_WR_WAIT  = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    state_t                  r_state;
    logic                    r_rmw;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_mask;
    logic [DATA_WIDTH-1:0]   r_old;
    logic [15:0]             r_cnt;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_timeout;
    logic                    r_drp_en;
    logic                    r_drp_we;
    logic [ADDR_WIDTH-1:0]   r_drp_addr;
    logic [DATA_WIDTH-1:0]   r_drp_di;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rmw         <= 1'b0;
            r_wdata       <= '0;
            r_mask        <= '0;
            r_old         <= '0;
            r_cnt         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
            r_drp_en      <= 1'b0;
            r_drp_we      <= 1'b0;
            r_drp_addr    <= '0;
            r_drp_di      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_drp_addr <= req_addr;
                        r_wdata    <= req_wdata;
                        r_mask     <= req_mask;
                        r_old      <= '0;
                        r_rmw      <= req_write && (req_mask != c_all_ones);
                        r_drp_en   <= 1'b1;
                        if (!req_write || (req_mask != c_all_ones)) begin
                            r_drp_we <= 1'b0;
                            r_state  <= S_RD_ISSUE;
                        end else begin
                            r_drp_we <= 1'b1;
                            r_drp_di <= req_wdata;
                            r_state  <= S_WR_ISSUE;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    r_drp_en <= 1'b0;
                    r_drp_we <= 1'b0;
                    r_cnt    <= '0;
                    r_state  <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (drp_rdy) begin
                        r_old <= drp_do;
                        if (r_rmw) begin
                            r_drp_en <= 1'b1;
                            r_drp_we <= 1'b1;
                            r_drp_di <= (drp_do & ~r_mask) | (r_wdata & r_mask);
                            r_state  <= S_WR_ISSUE;
                        end else begin
                            r_rsp_valid   <= 1'b1;
                            r_rsp_rdata   <= drp_do;
                            r_rsp_timeout <= 1'b0;
                            r_state       <= S_RESP;
                        end
                    end else if (r_cnt == c_cnt_last) begin
                        // A timed-out RMW read never reaches its write phase.
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_WR_ISSUE: begin
                    r_drp_en <= 1'b0;
                    r_drp_we <= 1'b0;
                    r_cnt    <= '0;
                    r_state  <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (drp_rdy) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_rmw ? r_old : '0;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= S_RESP;
                    end else if (r_cnt == c_cnt_last) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    r_rsp_valid   <= 1'b0;
                    r_rsp_rdata   <= '0;
                    r_rsp_timeout <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_timeout = r_rsp_timeout;
    assign drp_en      = r_drp_en;
    assign drp_we      = r_drp_we;
    assign drp_addr    = r_drp_addr;
    assign drp_di      = r_drp_di;

endmodule
`default_nettype wire

// File: tb/tb_drp_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_drp_master
// Purpose  : Self-checking bench for drp_master with a memory-backed DRP
//            responder and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drp_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write;
    logic        req_ready;
    logic [8:0]  req_addr;
    logic [15:0] req_wdata, req_mask;
    logic        rsp_valid, rsp_timeout, busy;
    logic [15:0] rsp_rdata;
    logic        drp_en, drp_we, drp_rdy;
    logic [8:0]  drp_addr;
    logic [15:0] drp_di, drp_do;

    drp_master #(.ADDR_WIDTH(9), .DATA_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .busy(busy), .drp_en(drp_en), .drp_we(drp_we), .drp_addr(drp_addr),
        .drp_di(drp_di), .drp_rdy(drp_rdy), .drp_do(drp_do)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [15:0] di;
        int          cyc;
    } acc_t;

    acc_t        acc_q[$];
    int          dly_q[$];
    logic [15:0] slave_mem[512];
    logic [15:0] ref_mem[512];
    int          cyc = 0;
    int          rsp_cnt = 0;
    int          overlap = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // DRP responder: answers each DEN after the next queued delay from a memory.
    initial begin
        int          cd;
        logic [15:0] cur;
        cd = 0;
        cur = '0;
        drp_rdy = 1'b0;
        drp_do = '0;
        forever begin
            @(negedge clk);
            drp_rdy = 1'b0;
            drp_do = 16'($urandom);
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    drp_rdy = 1'b1;
                    drp_do = cur;
                end
            end
            if (drp_en) begin
                if (cd > 0) overlap++;
                acc_q.push_back('{drp_we, drp_addr, drp_di, cyc});
                cur = slave_mem[drp_addr];
                if (drp_we) slave_mem[drp_addr] = drp_di;
                cd = (dly_q.size() > 0) ? dly_q.pop_front() : 1;
            end
            if (rsp_valid) rsp_cnt++;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_txn(input logic wr, input logic [8:0] a, input logic [15:0] wd,
                          input logic [15:0] mk, input int d1, input int d2);
        logic        rmw, rd_first, exp_to, got;
        logic [15:0] old, exp_rd, exp_di2;
        int          n_acc, d_last, base, cnt;
        rmw = wr && (mk != 16'hFFFF);
        rd_first = !wr || rmw;
        old = ref_mem[a];
        exp_rd = '0;
        exp_to = 1'b0;
        exp_di2 = '0;
        n_acc = 1;
        d_last = d1;
        if (!rd_first) begin
            ref_mem[a] = wd;
            exp_to = (d1 > TO);
        end else if (d1 > TO) begin
            exp_to = 1'b1;
        end else if (!rmw) begin
            exp_rd = old;
        end else begin
            n_acc = 2;
            d_last = d2;
            exp_di2 = (old & ~mk) | (wd & mk);
            ref_mem[a] = exp_di2;
            exp_to = (d2 > TO);
            exp_rd = exp_to ? 16'h0 : old;
        end
        acc_q.delete();
        dly_q.push_back(d1);
        if (n_acc == 2) dly_q.push_back(d2);
        base = rsp_cnt;

        for (cnt = 0; cnt < 50 && !req_ready; cnt++) @(negedge clk);
        check("req_ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr = a;
        req_wdata = wd;
        req_mask = mk;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 16'($urandom);
        req_mask = 16'($urandom);
        check("busy_ready_inflight", 32'({busy, req_ready}), 32'b10);

        got = 1'b0;
        for (cnt = 0; cnt < 40; cnt++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rsp_seen", 32'(got), 32'd1);
        if (got) begin
            check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
            check("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
            if (acc_q.size() > 0)
                check("rsp_latency", 32'(cyc - acc_q[acc_q.size()-1].cyc),
                      32'(((d_last > TO) ? TO : d_last) + 1));
        end
        check("drp_access_count", 32'(acc_q.size()), 32'(n_acc));
        if (acc_q.size() > 0) begin
            check("acc0_we_addr", 32'({acc_q[0].we, acc_q[0].addr}), 32'({!rd_first, a}));
            if (!rd_first) check("acc0_di", 32'(acc_q[0].di), 32'(wd));
        end
        if (n_acc == 2 && acc_q.size() > 1) begin
            check("acc1_we_addr", 32'({acc_q[1].we, acc_q[1].addr}), 32'({1'b1, a}));
            check("acc1_di", 32'(acc_q[1].di), 32'(exp_di2));
        end
        idle(4);
        check("rsp_pulse_count", 32'(rsp_cnt - base), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 32'({rsp_valid, rsp_timeout, busy, drp_en, drp_we}), 32'd0);
        check({tag, "_data"}, 32'({rsp_rdata, drp_addr}), 32'd0);
        check({tag, "_di"}, 32'(drp_di), 32'd0);
    endtask

    initial begin
        int base, got, i;
        logic [8:0]  b_addr[3];
        logic [15:0] b_exp[3];
        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_mask = '0;
        for (int k = 0; k < 512; k++) begin
            slave_mem[k] = 16'($urandom);
            ref_mem[k] = slave_mem[k];
        end
        idle(3);
        check_reset_outputs("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);

        slave_mem[9'h05A] = 16'hBEEF;
        ref_mem[9'h05A] = 16'hBEEF;
        do_txn(1'b0, 9'h05A, 16'h0, 16'h0, 3, 0);
        do_txn(1'b1, 9'h1FF, 16'h1234, 16'hFFFF, 2, 0);
        check("write_mem", 32'(slave_mem[9'h1FF]), 32'h1234);
        slave_mem[9'h010] = 16'hA5A5;
        ref_mem[9'h010] = 16'hA5A5;
        do_txn(1'b1, 9'h010, 16'h00FF, 16'h0F0F, 1, 2);
        check("rmw_mem", 32'(slave_mem[9'h010]), 32'hA0AF);
        do_txn(1'b0, 9'h033, 16'h0, 16'h0, TO + 2, 0);
        do_txn(1'b0, 9'h033, 16'h0, 16'h0, 1, 0);
        do_txn(1'b0, 9'h034, 16'h0, 16'h0, TO, 0);
        do_txn(1'b0, 9'h035, 16'h0, 16'h0, TO + 1, 0);
        do_txn(1'b1, 9'h036, 16'h5555, 16'h00F0, TO + 1, 1);

        // Reset abort during RD_WAIT; the pending DRDY lands after reset.
        base = rsp_cnt;
        acc_q.delete();
        dly_q.push_back(3);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 9'h044;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(req_ready), 32'd1);
        idle(4);
        check("abort_no_rsp", 32'(rsp_cnt - base), 32'd0);
        check_reset_outputs("abort_idle");

        // Back-to-back reads with req_valid held high.
        acc_q.delete();
        for (int k = 0; k < 3; k++) begin
            b_addr[k] = 9'(9'h100 + k * 7);
            b_exp[k] = ref_mem[b_addr[k]];
            dly_q.push_back(k + 1);
        end
        got = 0;
        i = 0;
        for (int c = 0; c < 80 && got < 3; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (got < 3) check("b2b_rdata", 32'(rsp_rdata), 32'(b_exp[got]));
                got++;
            end
            if (i < 3 && req_ready) begin
                req_valid = 1'b1;
                req_write = 1'b0;
                req_addr = b_addr[i];
                i++;
            end else if (i == 3) begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check("b2b_rsp_count", 32'(got), 32'd3);
        check("b2b_access_count", 32'(acc_q.size()), 32'd3);
        if (acc_q.size() == 3)
            check("b2b_order", 32'({acc_q[0].addr, acc_q[1].addr, acc_q[2].addr}),
                  32'({b_addr[0], b_addr[1], b_addr[2]}));
        idle(4);

        for (int t = 0; t < 40; t++) begin
            logic        wr;
            logic [15:0] mk;
            wr = 1'($urandom_range(0, 1));
            mk = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
            do_txn(wr, 9'($urandom_range(0, 15)), 16'($urandom), mk,
                   $urandom_range(1, TO + 2), $urandom_range(1, TO + 2));
        end
        for (int k = 0; k < 16; k++)
            check("final_mem", 32'(slave_mem[k]), 32'(ref_mem[k]));
        check("drp_overlap", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
